// File: rtl/round_pkg.sv
// Shared types and BCD helpers for the round clock.
package round_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        PLAY   = 2'd2,
        TIMEUP = 2'd3
    } phase_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    function automatic bcd_t to_bcd(int unsigned n);
        bcd_t r;
        r.tens = 4'(n / 10);
        r.ones = 4'(n % 10);
        return r;
    endfunction

    // Saturates at 00 so the pair never underflows.
    function automatic bcd_t bcd_dec(bcd_t v);
        bcd_t r;
        r = v;
        if (v.ones != 4'd0) begin
            r.ones = v.ones - 4'd1;
        end else if (v.tens != 4'd0) begin
            r.ones = DIGIT_MAX;
            r.tens = v.tens - 4'd1;
        end
        return r;
    endfunction

    // Saturates at 99.
    function automatic bcd_t bcd_inc(bcd_t v);
        bcd_t r;
        r = v;
        if (v.ones < DIGIT_MAX) begin
            r.ones = v.ones + 4'd1;
        end else if (v.tens < DIGIT_MAX) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/round_tick_detect.sv
// Turns changes of the upstream seconds digit into one-second ticks.
module round_tick_detect
    import round_pkg::*;
(
    input  logic       frameclk,
    input  logic       Reset,
    input  logic [3:0] currNum,
    output logic       tick_now,
    output logic       tick
);

    logic [3:0] last_digit;

    // Transient values 10-15 neither tick nor update the remembered digit.
    assign tick_now = (currNum <= DIGIT_MAX) && (currNum != last_digit);

    always_ff @(posedge frameclk) begin
        if (Reset) begin
            last_digit <= 4'd0;
            tick       <= 1'b0;
        end else begin
            tick <= tick_now;
            if (tick_now) begin
                last_digit <= currNum;
            end
        end
    end

endmodule

// File: rtl/round_clock.sv
// Game-round sequencer: ready count, BCD play-time countdown and time-up.
module round_clock
    import round_pkg::*;
#(
    parameter int unsigned ROUND_SECS = 60,
    parameter int unsigned READY_SECS = 3
) (
    input  logic       frameclk,
    input  logic       Reset,
    input  logic [3:0] currNum,
    input  logic       control_EN,
    input  logic       start,
    input  logic       pause,
    output logic [1:0] phase,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic [3:0] ready_cnt,
    output logic       game_active,
    output logic       time_up,
    output logic       tick
);

    localparam bcd_t       ROUND_BCD  = to_bcd(ROUND_SECS);
    localparam logic [3:0] READY_LOAD = 4'(READY_SECS);

    phase_t     phase_q;
    bcd_t       bcd_q;
    logic [3:0] ready_q;
    logic       tick_now;
    logic       arm;

    round_tick_detect u_tick (
        .frameclk (frameclk),
        .Reset    (Reset),
        .currNum  (currNum),
        .tick_now (tick_now),
        .tick     (tick)
    );

    assign arm = start && control_EN;

    always_ff @(posedge frameclk) begin
        if (Reset) begin
            phase_q <= IDLE;
            bcd_q   <= ROUND_BCD;
            ready_q <= 4'd0;
            time_up <= 1'b0;
        end else begin
            time_up <= 1'b0;
            case (phase_q)
                IDLE: begin
                    bcd_q   <= ROUND_BCD;
                    ready_q <= 4'd0;
                    if (arm) begin
                        phase_q <= READY;
                        ready_q <= READY_LOAD;
                    end
                end
                READY: begin
                    if (tick_now) begin
                        if (ready_q <= 4'd1) begin
                            phase_q <= PLAY;
                            bcd_q   <= ROUND_BCD;
                            ready_q <= 4'd0;
                        end else begin
                            ready_q <= ready_q - 4'd1;
                        end
                    end
                end
                PLAY: begin
                    // Paused ticks are dropped, not queued.
                    if (tick_now && !pause) begin
                        if (bcd_q.tens == 4'd0 && bcd_q.ones <= 4'd1) begin
                            phase_q <= TIMEUP;
                            bcd_q   <= '0;
                            time_up <= 1'b1;
                        end else begin
                            bcd_q <= bcd_dec(bcd_q);
                        end
                    end
                end
                TIMEUP: begin
                    bcd_q <= '0;
                    if (arm) begin
                        phase_q <= READY;
                        ready_q <= READY_LOAD;
                        bcd_q   <= ROUND_BCD;
                    end
                end
                default: begin
                    phase_q <= IDLE;
                end
            endcase
        end
    end

    assign phase       = phase_q;
    assign secs_tens   = bcd_q.tens;
    assign secs_ones   = bcd_q.ones;
    assign ready_cnt   = ready_q;
    assign game_active = (phase_q == PLAY) && !pause;

endmodule

// File: tb/tb_round_clock.sv
// Scoreboard bench: default instance (60/3) and a short-round instance (3/2).
module tb_round_clock;
    import round_pkg::*;

    logic       frameclk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] currNum = 4'd0;
    logic       control_EN = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [1:0] phase_a, phase_b;
    logic [3:0] tens_a, ones_a, ready_a, tens_b, ones_b, ready_b;
    logic       ga_a, tu_a, tick_a, ga_b, tu_b, tick_b;
    logic [16:0] obs, obs3;

    int checks = 0;
    int errors = 0;
    int cur = 0;

    typedef struct {
        logic [3:0]  d;
        logic        s, en, p, rst;
        logic [16:0] v;
        bit          use3;
        string       name;
    } row_t;

    typedef struct {
        logic [16:0] v;
        bit          use3;
        string       name;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];

    always #5 frameclk = ~frameclk;

    round_clock dut (
        .frameclk    (frameclk),
        .Reset       (Reset),
        .currNum     (currNum),
        .control_EN  (control_EN),
        .start       (start),
        .pause       (pause),
        .phase       (phase_a),
        .secs_tens   (tens_a),
        .secs_ones   (ones_a),
        .ready_cnt   (ready_a),
        .game_active (ga_a),
        .time_up     (tu_a),
        .tick        (tick_a)
    );

    round_clock #(.ROUND_SECS(3), .READY_SECS(2)) dut3 (
        .frameclk    (frameclk),
        .Reset       (Reset),
        .currNum     (currNum),
        .control_EN  (control_EN),
        .start       (start),
        .pause       (pause),
        .phase       (phase_b),
        .secs_tens   (tens_b),
        .secs_ones   (ones_b),
        .ready_cnt   (ready_b),
        .game_active (ga_b),
        .time_up     (tu_b),
        .tick        (tick_b)
    );

    assign obs  = {phase_a, tens_a, ones_a, ready_a, tick_a, tu_a, ga_a};
    assign obs3 = {phase_b, tens_b, ones_b, ready_b, tick_b, tu_b, ga_b};

    function automatic logic [16:0] mk(phase_t ph, int t, int o, int r,
                                       logic tk, logic tu, logic ga);
        return {ph, 4'(t), 4'(o), 4'(r), tk, tu, ga};
    endfunction

    task automatic add(input int d, input logic s, input logic en, input logic p,
                       input logic rst, input logic [16:0] v, input bit use3,
                       input string name);
        row_t r;
        r.d = 4'(d); r.s = s; r.en = en; r.p = p; r.rst = rst;
        r.v = v; r.use3 = use3; r.name = name;
        rows.push_back(r);
    endtask

    function automatic int nextd();
        cur = (cur + 1) % 10;
        return cur;
    endfunction

    task automatic test_reset();
        row_t r; exp_t e; logic [16:0] got;
        add(0, 0, 0, 0, 1, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "reset_c1");
        add(0, 0, 0, 0, 1, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "reset_c2");
        add(1, 0, 1, 0, 0, mk(IDLE, 6, 0, 0, 1, 0, 0), 0, "idle_tick1");
        add(2, 0, 1, 0, 0, mk(IDLE, 6, 0, 0, 1, 0, 0), 0, "idle_tick2");
        add(2, 0, 1, 0, 0, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "idle_hold");
        cur = 2;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            sb.push_back('{v: r.v, use3: r.use3, name: r.name});
            Reset = r.rst; currNum = r.d; start = r.s; control_EN = r.en; pause = r.p;
            @(posedge frameclk); #1;
            e = sb.pop_front(); checks++;
            got = e.use3 ? obs3 : obs;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_invalid_filter();
        row_t r; exp_t e; logic [16:0] got;
        add(9,  0, 0, 0, 0, mk(IDLE, 6, 0, 0, 1, 0, 0), 0, "filt_9");
        add(10, 0, 0, 0, 0, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "filt_10");
        add(15, 0, 0, 0, 0, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "filt_15");
        add(0,  0, 0, 0, 0, mk(IDLE, 6, 0, 0, 1, 0, 0), 0, "filt_0");
        add(0,  0, 0, 0, 0, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "filt_hold");
        cur = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            sb.push_back('{v: r.v, use3: r.use3, name: r.name});
            Reset = r.rst; currNum = r.d; start = r.s; control_EN = r.en; pause = r.p;
            @(posedge frameclk); #1;
            e = sb.pop_front(); checks++;
            got = e.use3 ? obs3 : obs;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_arm_gating();
        row_t r; exp_t e; logic [16:0] got;
        add(0, 1, 0, 0, 0, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "start_no_arm");
        // Start and tick together: ready count loads without being decremented.
        add(nextd(), 1, 1, 0, 0, mk(READY, 6, 0, 3, 1, 0, 0), 0, "start_with_tick");
        while (rows.size() > 0) begin
            r = rows.pop_front();
            sb.push_back('{v: r.v, use3: r.use3, name: r.name});
            Reset = r.rst; currNum = r.d; start = r.s; control_EN = r.en; pause = r.p;
            @(posedge frameclk); #1;
            e = sb.pop_front(); checks++;
            got = e.use3 ? obs3 : obs;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_pause();
        row_t r; exp_t e; logic [16:0] got;
        add(nextd(), 0, 1, 1, 0, mk(READY, 6, 0, 2, 1, 0, 0), 0, "ready_pause_ignored");
        add(nextd(), 0, 1, 0, 0, mk(READY, 6, 0, 1, 1, 0, 0), 0, "ready_1");
        add(nextd(), 0, 1, 0, 0, mk(PLAY, 6, 0, 0, 1, 0, 1), 0, "enter_play");
        for (int i = 1; i <= 50; i++) begin
            add(nextd(), 1, 1, 0, 0, mk(PLAY, (60 - i) / 10, (60 - i) % 10, 0, 1, 0, 1),
                0, "play_count");
        end
        for (int i = 0; i < 3; i++) begin
            add(nextd(), 0, 1, 1, 0, mk(PLAY, 1, 0, 0, 1, 0, 0), 0, "paused_tick");
        end
        add(cur, 0, 1, 0, 0, mk(PLAY, 1, 0, 0, 0, 0, 1), 0, "pause_release");
        add(nextd(), 0, 1, 0, 0, mk(PLAY, 0, 9, 0, 1, 0, 1), 0, "borrow_10_09");
        while (rows.size() > 0) begin
            r = rows.pop_front();
            sb.push_back('{v: r.v, use3: r.use3, name: r.name});
            Reset = r.rst; currNum = r.d; start = r.s; control_EN = r.en; pause = r.p;
            @(posedge frameclk); #1;
            e = sb.pop_front(); checks++;
            got = e.use3 ? obs3 : obs;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        row_t r; exp_t e; logic [16:0] got;
        add(0, 0, 0, 0, 1, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "rst_pre");
        cur = 0;
        add(0, 1, 1, 0, 0, mk(READY, 6, 0, 3, 0, 0, 0), 0, "rst_start");
        add(nextd(), 0, 1, 0, 0, mk(READY, 6, 0, 2, 1, 0, 0), 0, "rst_ready2");
        add(nextd(), 0, 1, 0, 0, mk(READY, 6, 0, 1, 1, 0, 0), 0, "rst_ready1");
        add(nextd(), 0, 1, 0, 0, mk(PLAY, 6, 0, 0, 1, 0, 1), 0, "rst_play");
        for (int i = 1; i <= 19; i++) begin
            add(nextd(), 0, 1, 0, 0, mk(PLAY, (60 - i) / 10, (60 - i) % 10, 0, 1, 0, 1),
                0, "rst_count");
        end
        add(nextd(), 0, 1, 0, 1, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "reset_at_41");
        add(0, 0, 1, 0, 1, mk(IDLE, 6, 0, 0, 0, 0, 0), 0, "reset_hold");
        cur = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            sb.push_back('{v: r.v, use3: r.use3, name: r.name});
            Reset = r.rst; currNum = r.d; start = r.s; control_EN = r.en; pause = r.p;
            @(posedge frameclk); #1;
            e = sb.pop_front(); checks++;
            got = e.use3 ? obs3 : obs;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_full_round();
        row_t r; exp_t e; logic [16:0] got;
        add(0, 0, 0, 0, 1, mk(IDLE, 0, 3, 0, 0, 0, 0), 1, "short_reset");
        cur = 0;
        add(0, 1, 1, 0, 0, mk(READY, 0, 3, 2, 0, 0, 0), 1, "short_start");
        add(nextd(), 0, 1, 0, 0, mk(READY, 0, 3, 1, 1, 0, 0), 1, "short_ready1");
        add(nextd(), 0, 1, 0, 0, mk(PLAY, 0, 3, 0, 1, 0, 1), 1, "short_play03");
        add(nextd(), 0, 1, 0, 0, mk(PLAY, 0, 2, 0, 1, 0, 1), 1, "short_play02");
        add(nextd(), 0, 1, 0, 0, mk(PLAY, 0, 1, 0, 1, 0, 1), 1, "short_play01");
        add(nextd(), 0, 1, 0, 0, mk(TIMEUP, 0, 0, 0, 1, 1, 0), 1, "short_timeup");
        add(cur, 0, 1, 0, 0, mk(TIMEUP, 0, 0, 0, 0, 0, 0), 1, "timeup_pulse_end");
        add(nextd(), 0, 1, 0, 0, mk(TIMEUP, 0, 0, 0, 1, 0, 0), 1, "timeup_hold00");
        while (rows.size() > 0) begin
            r = rows.pop_front();
            sb.push_back('{v: r.v, use3: r.use3, name: r.name});
            Reset = r.rst; currNum = r.d; start = r.s; control_EN = r.en; pause = r.p;
            @(posedge frameclk); #1;
            e = sb.pop_front(); checks++;
            got = e.use3 ? obs3 : obs;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t r; exp_t e; logic [16:0] got;
        add(cur, 1, 0, 0, 0, mk(TIMEUP, 0, 0, 0, 0, 0, 0), 1, "timeup_no_arm");
        add(nextd(), 1, 1, 0, 0, mk(READY, 0, 3, 2, 1, 0, 0), 1, "restart_with_tick");
        add(cur, 0, 1, 0, 0, mk(READY, 0, 3, 2, 0, 0, 0), 1, "restart_hold");
        add(nextd(), 0, 1, 0, 0, mk(READY, 0, 3, 1, 1, 0, 0), 1, "restart_ready1");
        add(nextd(), 0, 1, 0, 0, mk(PLAY, 0, 3, 0, 1, 0, 1), 1, "restart_play");
        add(nextd(), 1, 1, 0, 0, mk(PLAY, 0, 2, 0, 1, 0, 1), 1, "start_ignored_play");
        while (rows.size() > 0) begin
            r = rows.pop_front();
            sb.push_back('{v: r.v, use3: r.use3, name: r.name});
            Reset = r.rst; currNum = r.d; start = r.s; control_EN = r.en; pause = r.p;
            @(posedge frameclk); #1;
            e = sb.pop_front(); checks++;
            got = e.use3 ? obs3 : obs;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", e.name, got, e.v);
            end
        end
    endtask

    initial begin
        @(posedge frameclk); #1;
        test_reset();
        test_invalid_filter();
        test_arm_gating();
        test_pause();
        test_reset_mid_play();
        test_full_round();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
